// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned RAM_ADDR_W = 8;
  localparam int unsigned RAM_DATA_W = 8;
  localparam int unsigned CNT_W      = 4;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant selection; on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_c,
  output logic valid_c
);

  always_comb begin
    valid_c = req0 | req1;
    grant_c = 1'b0;
    if (req0 && req1) begin
      grant_c = ~last_grant;
    end else if (req1) begin
      grant_c = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM with a fixed access wait.
// Optional ROUND_ROBIN_EN: alternate grants on ties instead of fixed req0 priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = RAM_ADDR_W,
  parameter int unsigned DATA_W      = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant;
  logic             w_take;
  logic             w_done;
  logic             w_arb_grant;
  logic             w_arb_valid;
  logic             w_last_grant;

`ifdef ROUND_ROBIN_EN
  logic r_last_grant;

  // Remembers the most recent winner so the next tie goes the other way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_take) begin
      r_last_grant <= w_arb_grant;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  // Constant 1 makes every tie resolve to requester 0.
  assign w_last_grant = 1'b1;
`endif

  rr_arbiter2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (w_last_grant),
    .grant_c    (w_arb_grant),
    .valid_c    (w_arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_next = ACCESS;
          w_take = 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_next = DONE;
          w_done = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The ram_* registers double as the latched command for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_grant     <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      dout        <= '0;
      busy        <= 1'b0;
      ram_enable  <= 1'b0;
      ram_rw      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= (w_next != IDLE);
      if (w_take) begin
        r_grant     <= w_arb_grant;
        r_cnt       <= CNT_LOAD;
        ram_enable  <= 1'b1;
        ram_rw      <= w_arb_grant ? rw1 : rw0;
        ram_address <= w_arb_grant ? addr1 : addr0;
        ram_data_in <= w_arb_grant ? din1 : din0;
      end else if (w_done) begin
        if (ram_rw == READ) begin
          dout <= ram_data_out;
        end
        ack0        <= ~r_grant;
        ack1        <= r_grant;
        ram_enable  <= 1'b0;
        ram_rw      <= 1'b0;
        ram_address <= '0;
        ram_data_in <= '0;
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
